// File: rtl/pong_game_engine.sv
// pong_game_engine
//   Game-state generator feeding the 64x64 LED frame renderer. Owns ball
//   motion, wall and paddle reflection, paddle control, scoring and the
//   serve / point / game-over sequencing. Every output is a register.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tick       one-cycle frame-rate enable pulse
//   start      level; begins a game from IDLE or OVER
//   p1_up/dn   P1 paddle up (towards row 0) / down
//   p2_up/dn   P2 paddle up / down
//   bx, by     ball column / row
//   p1y, p2y   paddle top rows (P1 at columns 0-1, P2 at columns 62-63)
//   sc1, sc2   scores
//   game_over  high while in OVER
//   winner     0 = P1, 1 = P2; meaningful while game_over is high
module pong_game_engine #(
  parameter int PADDLE_H    = 6,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 30,
  parameter int BALL_DIV    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [5:0] bx,
  output logic [5:0] by,
  output logic [5:0] p1y,
  output logic [5:0] p2y,
  output logic [2:0] sc1,
  output logic [2:0] sc2,
  output logic       game_over,
  output logic       winner
);

  localparam int SERVE_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int BALL_W  = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;

  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_TICKS - 1);
  localparam logic [BALL_W-1:0]  BALL_LAST  = BALL_W'(BALL_DIV - 1);
  localparam logic [5:0]         PADDLE_MAX = 6'(64 - PADDLE_H);
  localparam logic [5:0]         HOME       = 6'd31;
  localparam logic [5:0]         PADDLE_RST = 6'd29;
  localparam logic [2:0]         WIN3       = 3'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_OVER
  } state_t;

  state_t             state, state_n;
  logic [5:0]         bx_n, by_n, p1y_n, p2y_n;
  logic [2:0]         sc1_n, sc2_n, pt_score;
  logic               game_over_n, winner_n;
  // Directions are kept as "moving towards smaller coordinate" flags.
  logic               dx_neg, dx_neg_n, dy_neg, dy_neg_n;
  logic               scorer, scorer_n;
  logic [SERVE_W-1:0] serve_cnt, serve_cnt_n;
  logic [BALL_W-1:0]  ball_cnt, ball_cnt_n;

  // Paddle step: one row per tick, saturating at both ends; both or
  // neither button held means hold.
  function automatic logic [5:0] paddle_move(input logic [5:0] top,
                                             input logic up,
                                             input logic dn);
    paddle_move = top;
    if (up && !dn && top != 6'd0)
      paddle_move = top - 6'd1;
    else if (dn && !up && top < PADDLE_MAX)
      paddle_move = top + 6'd1;
  endfunction

  // Widened to 7 bits so top+PADDLE_H-1 cannot wrap.
  function automatic logic in_paddle(input logic [5:0] y, input logic [5:0] top);
    logic [6:0] lo;
    logic [6:0] hi;
    lo = {1'b0, top};
    hi = lo + 7'(PADDLE_H - 1);
    in_paddle = ({1'b0, y} >= lo) && ({1'b0, y} <= hi);
  endfunction

  // Scores stop at WIN_SCORE instead of wrapping.
  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    sat_inc = (s == WIN3) ? s : s + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bx        <= HOME;
      by        <= HOME;
      p1y       <= PADDLE_RST;
      p2y       <= PADDLE_RST;
      sc1       <= 3'd0;
      sc2       <= 3'd0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      scorer    <= 1'b0;
      serve_cnt <= '0;
      ball_cnt  <= '0;
    end else begin
      state     <= state_n;
      bx        <= bx_n;
      by        <= by_n;
      p1y       <= p1y_n;
      p2y       <= p2y_n;
      sc1       <= sc1_n;
      sc2       <= sc2_n;
      game_over <= game_over_n;
      winner    <= winner_n;
      dx_neg    <= dx_neg_n;
      dy_neg    <= dy_neg_n;
      scorer    <= scorer_n;
      serve_cnt <= serve_cnt_n;
      ball_cnt  <= ball_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    bx_n        = bx;
    by_n        = by;
    p1y_n       = p1y;
    p2y_n       = p2y;
    sc1_n       = sc1;
    sc2_n       = sc2;
    game_over_n = game_over;
    winner_n    = winner;
    dx_neg_n    = dx_neg;
    dy_neg_n    = dy_neg;
    scorer_n    = scorer;
    serve_cnt_n = serve_cnt;
    ball_cnt_n  = ball_cnt;
    pt_score    = 3'd0;

    if (tick && (state == S_SERVE || state == S_PLAY || state == S_POINT)) begin
      p1y_n = paddle_move(p1y, p1_up, p1_dn);
      p2y_n = paddle_move(p2y, p2_up, p2_dn);
    end

    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_n     = S_SERVE;
          sc1_n       = 3'd0;
          sc2_n       = 3'd0;
          game_over_n = 1'b0;
          bx_n        = HOME;
          by_n        = HOME;
          dx_neg_n    = 1'b0;
          dy_neg_n    = 1'b0;
          serve_cnt_n = '0;
        end
      end

      S_SERVE: begin
        if (tick) begin
          if (serve_cnt == SERVE_LAST) begin
            state_n    = S_PLAY;
            ball_cnt_n = '0;
          end else begin
            serve_cnt_n = serve_cnt + SERVE_W'(1);
          end
        end
      end

      S_PLAY: begin
        if (tick) begin
          if (ball_cnt == BALL_LAST) begin
            ball_cnt_n = '0;
            // Vertical: reflect off rows 0 and 63. Applied even on a miss.
            if (dy_neg && by == 6'd0) begin
              by_n     = 6'd1;
              dy_neg_n = 1'b0;
            end else if (!dy_neg && by == 6'd63) begin
              by_n     = 6'd62;
              dy_neg_n = 1'b1;
            end else begin
              by_n = dy_neg ? by - 6'd1 : by + 6'd1;
            end
            // Horizontal: paddle faces are columns 2 and 61; hit test
            // uses the pre-step row and the pre-tick paddle position.
            if (dx_neg && bx == 6'd2) begin
              if (in_paddle(by, p1y)) begin
                bx_n     = 6'd3;
                dx_neg_n = 1'b0;
              end else begin
                scorer_n = 1'b1;
                state_n  = S_POINT;
              end
            end else if (!dx_neg && bx == 6'd61) begin
              if (in_paddle(by, p2y)) begin
                bx_n     = 6'd60;
                dx_neg_n = 1'b1;
              end else begin
                scorer_n = 1'b0;
                state_n  = S_POINT;
              end
            end else begin
              bx_n = dx_neg ? bx - 6'd1 : bx + 6'd1;
            end
          end else begin
            ball_cnt_n = ball_cnt + BALL_W'(1);
          end
        end
      end

      S_POINT: begin
        pt_score = scorer ? sat_inc(sc2) : sat_inc(sc1);
        if (scorer)
          sc2_n = pt_score;
        else
          sc1_n = pt_score;
        if (pt_score == WIN3) begin
          state_n     = S_OVER;
          game_over_n = 1'b1;
          winner_n    = scorer;
        end else begin
          // Next serve heads towards the player who lost the point.
          state_n     = S_SERVE;
          bx_n        = HOME;
          by_n        = HOME;
          dx_neg_n    = scorer;
          dy_neg_n    = 1'b0;
          serve_cnt_n = '0;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
